// File: rtl/cellrv32_package.sv
// Shared types for the vector register file write-back path: request payload,
// source select, and the per-register pending helper.
package cellrv32_package;

    localparam int unsigned VRF_VREGS    = 32;
    localparam int unsigned VRF_ELEMENTS = 4;
    localparam int unsigned VRF_DATA_W   = 32;
    localparam int unsigned VRF_ADDR_W   = $clog2(VRF_VREGS);

    typedef struct packed {
        logic [VRF_ADDR_W-1:0]              addr;
        logic [VRF_ELEMENTS-1:0]            mask;
        logic [VRF_ELEMENTS*VRF_DATA_W-1:0] data;
    } vrf_wb_req_t;

    typedef enum logic {
        SRC_EX = 1'b0,
        SRC_LD = 1'b1
    } vrf_wb_src_e;

    // One-hot register flag for a write; zero-mask writes never mark a register pending.
    function automatic logic [VRF_VREGS-1:0] vrf_wb_onehot(
        input logic [VRF_ADDR_W-1:0]   addr,
        input logic [VRF_ELEMENTS-1:0] mask
    );
        logic [VRF_VREGS-1:0] v;
        v = '0;
        if (|mask) v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/vrf_wb_fifo.sv
// Per-source write-back queue: power-of-two depth, refuses pushes while full
// (pop still proceeds), and reports which registers its queued entries target.
module vrf_wb_fifo
    import cellrv32_package::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic                 push_i,
    input  vrf_wb_req_t          din_i,
    input  logic                 pop_i,
    output vrf_wb_req_t          dout_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [VRF_VREGS-1:0] pend_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr, rd_ptr, count;
    vrf_wb_req_t mem [DEPTH];

    assign count   = wr_ptr - rd_ptr;
    assign empty_o = (count == '0);
    assign full_o  = (count == (PW+1)'(DEPTH));
    assign dout_o  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i && !empty_o) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem[wr_ptr[PW-1:0]] <= din_i;
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        logic [PW-1:0] off;
        off    = '0;
        pend_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            off = PW'(k) - rd_ptr[PW-1:0];
            if ({1'b0, off} < count) pend_o = pend_o | vrf_wb_onehot(mem[k].addr, mem[k].mask);
        end
    end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Arbitrates execution-unit register writes and load-unit element writes onto
// the two VRF write ports, merging disjoint-mask writes to the same register.
module vrf_wb_arbiter
    import cellrv32_package::*;
#(
    parameter int unsigned VREGS      = VRF_VREGS,
    parameter int unsigned ELEMENTS   = VRF_ELEMENTS,
    parameter int unsigned DATA_WIDTH = VRF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset,
    input  logic                                 ex_valid_i,
    output logic                                 ex_ready_o,
    input  logic [$clog2(VREGS)-1:0]             ex_addr_i,
    input  logic [ELEMENTS-1:0]                  ex_mask_i,
    input  logic [ELEMENTS*DATA_WIDTH-1:0]       ex_data_i,
    input  logic                                 ld_valid_i,
    output logic                                 ld_ready_o,
    input  logic [$clog2(VREGS)-1:0]             ld_addr_i,
    input  logic [ELEMENTS-1:0]                  ld_mask_i,
    input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  ld_data_i,
    output logic [ELEMENTS-1:0]                  v_wr_en,
    output logic [$clog2(VREGS)-1:0]             v_wr_addr,
    output logic [ELEMENTS*DATA_WIDTH-1:0]       v_wr_data,
    output logic [ELEMENTS-1:0]                  el_wr_en,
    output logic [$clog2(VREGS)-1:0]             el_wr_addr,
    output logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  el_wr_data,
    output logic [VREGS-1:0]                     pend_o,
    output logic                                 idle_o
);

    vrf_wb_req_t          ex_req, ld_req, ex_head, ld_head;
    logic                 ex_full, ex_empty, ld_full, ld_empty;
    logic [VREGS-1:0]     ex_pend, ld_pend;
    logic                 merge, grant_ex, grant_ld;
    vrf_wb_src_e          rr;

    assign ex_req = '{addr: ex_addr_i, mask: ex_mask_i, data: ex_data_i};
    assign ld_req = '{addr: ld_addr_i, mask: ld_mask_i, data: ld_data_i};

    assign ex_ready_o = !ex_full;
    assign ld_ready_o = !ld_full;

    vrf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_ex_fifo (
        .clk_i   (clk_i),
        .reset   (reset),
        .push_i  (ex_valid_i),
        .din_i   (ex_req),
        .pop_i   (grant_ex),
        .dout_o  (ex_head),
        .full_o  (ex_full),
        .empty_o (ex_empty),
        .pend_o  (ex_pend)
    );

    vrf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_ld_fifo (
        .clk_i   (clk_i),
        .reset   (reset),
        .push_i  (ld_valid_i),
        .din_i   (ld_req),
        .pop_i   (grant_ld),
        .dout_o  (ld_head),
        .full_o  (ld_full),
        .empty_o (ld_empty),
        .pend_o  (ld_pend)
    );

    // Same register with disjoint masks can retire both heads in one cycle.
    assign merge    = !ex_empty && !ld_empty && (ex_head.addr == ld_head.addr)
                      && ((ex_head.mask & ld_head.mask) == '0);
    assign grant_ex = !ex_empty && (ld_empty || merge || rr == SRC_EX);
    assign grant_ld = !ld_empty && (ex_empty || merge || rr == SRC_LD);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            rr         <= SRC_EX;
            v_wr_en    <= '0;
            v_wr_addr  <= '0;
            v_wr_data  <= '0;
            el_wr_en   <= '0;
            el_wr_addr <= '0;
            el_wr_data <= '0;
        end else begin
            v_wr_en    <= grant_ex ? ex_head.mask : '0;
            v_wr_addr  <= grant_ex ? ex_head.addr : '0;
            v_wr_data  <= grant_ex ? ex_head.data : '0;
            el_wr_en   <= grant_ld ? ld_head.mask : '0;
            el_wr_addr <= grant_ld ? ld_head.addr : '0;
            el_wr_data <= grant_ld ? ld_head.data : '0;
            if (grant_ex && !grant_ld)      rr <= SRC_LD;
            else if (grant_ld && !grant_ex) rr <= SRC_EX;
        end
    end

    assign pend_o = ex_pend | ld_pend
                  | vrf_wb_onehot(v_wr_addr, v_wr_en)
                  | vrf_wb_onehot(el_wr_addr, el_wr_en);

    assign idle_o = ex_empty && ld_empty && (v_wr_en == '0) && (el_wr_en == '0);

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Randomized and directed bench for vrf_wb_arbiter against a queue-based
// reference model of the write-back rules.
module tb_vrf_wb_arbiter;
    import cellrv32_package::*;

    localparam int unsigned D = 2;

    logic              clk_i = 1'b0;
    logic              reset = 1'b1;
    logic              ex_valid_i = 1'b0, ld_valid_i = 1'b0;
    logic              ex_ready_o, ld_ready_o;
    logic [4:0]        ex_addr_i = '0, ld_addr_i = '0;
    logic [3:0]        ex_mask_i = '0, ld_mask_i = '0;
    logic [127:0]      ex_data_i = '0;
    logic [3:0][31:0]  ld_data_i = '0;
    logic [3:0]        v_wr_en, el_wr_en;
    logic [4:0]        v_wr_addr, el_wr_addr;
    logic [127:0]      v_wr_data;
    logic [3:0][31:0]  el_wr_data;
    logic [31:0]       pend_o;
    logic              idle_o;

    always #5 clk_i = ~clk_i;

    vrf_wb_arbiter #(.VREGS(32), .ELEMENTS(4), .DATA_WIDTH(32), .FIFO_DEPTH(D)) dut (
        .clk_i(clk_i), .reset(reset),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_addr_i(ex_addr_i),
        .ex_mask_i(ex_mask_i), .ex_data_i(ex_data_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i),
        .ld_mask_i(ld_mask_i), .ld_data_i(ld_data_i),
        .v_wr_en(v_wr_en), .v_wr_addr(v_wr_addr), .v_wr_data(v_wr_data),
        .el_wr_en(el_wr_en), .el_wr_addr(el_wr_addr), .el_wr_data(el_wr_data),
        .pend_o(pend_o), .idle_o(idle_o)
    );

    typedef struct {
        logic [4:0]   addr;
        logic [3:0]   mask;
        logic [127:0] data;
    } ent_t;

    ent_t m_qex[$], m_qld[$];   // model queues
    ent_t s_ex[$], s_ld[$];     // pending stimulus per source
    logic [3:0]   e_v_en = '0, e_el_en = '0;
    logic [4:0]   e_v_addr = '0, e_el_addr = '0;
    logic [127:0] e_v_data = '0, e_el_data = '0;
    bit           m_turn_ld = 1'b0;
    int           n_checks = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: one pop per source per cycle, merge on disjoint masks, else take turns.
    always @(posedge clk_i) begin : model
        bit   acc_ex, acc_ld, g_ex, g_ld;
        ent_t h;
        if (reset) begin
            m_qex.delete(); m_qld.delete();
            m_turn_ld = 1'b0;
            e_v_en = '0; e_v_addr = '0; e_v_data = '0;
            e_el_en = '0; e_el_addr = '0; e_el_data = '0;
        end else begin
            acc_ex = ex_valid_i && (m_qex.size() < D);
            acc_ld = ld_valid_i && (m_qld.size() < D);
            if (m_qex.size() > 0 && m_qld.size() > 0) begin
                if (m_qex[0].addr == m_qld[0].addr && (m_qex[0].mask & m_qld[0].mask) == 4'h0) begin
                    g_ex = 1'b1; g_ld = 1'b1;
                end else begin
                    g_ex = !m_turn_ld; g_ld = m_turn_ld;
                end
            end else begin
                g_ex = m_qex.size() > 0;
                g_ld = m_qld.size() > 0;
            end
            e_v_en = '0; e_v_addr = '0; e_v_data = '0;
            e_el_en = '0; e_el_addr = '0; e_el_data = '0;
            if (g_ex) begin
                h = m_qex.pop_front();
                e_v_en = h.mask; e_v_addr = h.addr; e_v_data = h.data;
            end
            if (g_ld) begin
                h = m_qld.pop_front();
                e_el_en = h.mask; e_el_addr = h.addr; e_el_data = h.data;
            end
            if (g_ex != g_ld) m_turn_ld = g_ex;
            if (acc_ex) m_qex.push_back(ent_t'{ex_addr_i, ex_mask_i, ex_data_i});
            if (acc_ld) m_qld.push_back(ent_t'{ld_addr_i, ld_mask_i, ld_data_i});
        end
    end

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        foreach (m_qex[i]) if (m_qex[i].mask != 4'h0) p[m_qex[i].addr] = 1'b1;
        foreach (m_qld[i]) if (m_qld[i].mask != 4'h0) p[m_qld[i].addr] = 1'b1;
        if (e_v_en != 4'h0)  p[e_v_addr]  = 1'b1;
        if (e_el_en != 4'h0) p[e_el_addr] = 1'b1;
        return p;
    endfunction

    task automatic compare_all();
        check_eq("v_wr_en",    v_wr_en,    e_v_en);
        check_eq("v_wr_addr",  v_wr_addr,  e_v_addr);
        check_eq("v_wr_data",  v_wr_data,  e_v_data);
        check_eq("el_wr_en",   el_wr_en,   e_el_en);
        check_eq("el_wr_addr", el_wr_addr, e_el_addr);
        check_eq("el_wr_data", el_wr_data, e_el_data);
        check_eq("ex_ready",   ex_ready_o, m_qex.size() < D);
        check_eq("ld_ready",   ld_ready_o, m_qld.size() < D);
        check_eq("pend",       pend_o,     model_pend());
        check_eq("idle",       idle_o,     m_qex.size() == 0 && m_qld.size() == 0
                                           && e_v_en == 4'h0 && e_el_en == 4'h0);
    endtask

    // Present stimulus heads, advance one clock, retire accepted stimulus, check at negedge.
    task automatic cycle(input bit gx, input bit gl);
        bit tx, tl;
        ex_valid_i = gx && s_ex.size() > 0;
        ld_valid_i = gl && s_ld.size() > 0;
        ex_addr_i = ex_valid_i ? s_ex[0].addr : '0;
        ex_mask_i = ex_valid_i ? s_ex[0].mask : '0;
        ex_data_i = ex_valid_i ? s_ex[0].data : '0;
        ld_addr_i = ld_valid_i ? s_ld[0].addr : '0;
        ld_mask_i = ld_valid_i ? s_ld[0].mask : '0;
        ld_data_i = ld_valid_i ? s_ld[0].data : '0;
        tx = ex_valid_i && !reset && m_qex.size() < D;
        tl = ld_valid_i && !reset && m_qld.size() < D;
        @(posedge clk_i);
        if (tx) s_ex.delete(0);
        if (tl) s_ld.delete(0);
        @(negedge clk_i);
        compare_all();
    endtask

    function automatic ent_t rand_ent(input int unsigned amax);
        ent_t e;
        e.addr = 5'($urandom_range(0, amax));
        e.mask = 4'($urandom_range(0, 15));
        e.data = {$urandom, $urandom, $urandom, $urandom};
        return e;
    endfunction

    initial begin : stim
        int  seq[$];
        bit  saw_low;
        int  guard;
        ent_t e;

        reset = 1'b1;
        cycle(0, 0);
        cycle(0, 0);
        check_eq("rst_ex_ready", ex_ready_o, 1'b1);
        check_eq("rst_ld_ready", ld_ready_o, 1'b1);
        check_eq("rst_pend", pend_o, 32'h0);
        check_eq("rst_idle", idle_o, 1'b1);
        check_eq("rst_v_en", v_wr_en, 4'h0);
        reset = 1'b0;
        cycle(0, 0);

        // Single ex write: queued one cycle, written the next.
        s_ex.push_back(ent_t'{5'd5, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11}});
        cycle(1, 0);
        check_eq("single_pend_t1", pend_o[5], 1'b1);
        check_eq("single_en_t1", v_wr_en, 4'h0);
        cycle(1, 0);
        check_eq("single_en_t2", v_wr_en, 4'hF);
        check_eq("single_addr_t2", v_wr_addr, 5'd5);
        check_eq("single_data_t2", v_wr_data, {32'h44, 32'h33, 32'h22, 32'h11});
        check_eq("single_pend_t2", pend_o[5], 1'b1);
        cycle(0, 0);
        check_eq("single_pend_t3", pend_o[5], 1'b0);
        check_eq("single_en_t3", v_wr_en, 4'h0);

        // Merge of disjoint masks to the same register.
        s_ex.push_back(ent_t'{5'd3, 4'h3, {$urandom, $urandom, $urandom, $urandom}});
        s_ld.push_back(ent_t'{5'd3, 4'hC, {$urandom, $urandom, $urandom, $urandom}});
        cycle(1, 1);
        cycle(1, 1);
        check_eq("merge_v_en", v_wr_en, 4'h3);
        check_eq("merge_el_en", el_wr_en, 4'hC);
        check_eq("merge_v_addr", v_wr_addr, 5'd3);
        check_eq("merge_el_addr", el_wr_addr, 5'd3);
        cycle(0, 0);

        // Conflicting streams from a freshly reset pointer alternate ex,ld,...
        reset = 1'b1;
        cycle(0, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_ex.push_back(ent_t'{5'd3, 4'hF, 128'(i + 100)});
            s_ld.push_back(ent_t'{5'd7, 4'hF, 128'(i + 200)});
        end
        for (int i = 0; i < 14; i++) begin
            cycle(1, 1);
            if (v_wr_en != 4'h0)  seq.push_back(0);
            if (el_wr_en != 4'h0) seq.push_back(1);
        end
        check_eq("rr_count", seq.size(), 8);
        for (int i = 0; i < seq.size() && i < 8; i++) check_eq("rr_order", seq[i], i % 2);

        // Ex held valid against competing ld traffic: back-pressure must appear.
        saw_low = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_ex.push_back(ent_t'{5'd2, 4'hF, 128'(i + 300)});
            s_ld.push_back(ent_t'{5'd2, 4'hF, 128'(i + 400)});
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1);
            if (!ex_ready_o) saw_low = 1'b1;
        end
        check_eq("bp_ex_ready_low", saw_low, 1'b1);
        check_eq("bp_drained", s_ex.size() + s_ld.size(), 0);

        // Reset with loaded queues discards everything.
        for (int i = 0; i < 3; i++) begin
            s_ex.push_back(ent_t'{5'd1, 4'hF, 128'(i + 500)});
            s_ld.push_back(ent_t'{5'd1, 4'hF, 128'(i + 600)});
        end
        cycle(1, 1); cycle(1, 1); cycle(1, 1);
        check_eq("loaded_backpressure", !ex_ready_o || !ld_ready_o, 1'b1);
        reset = 1'b1;
        cycle(0, 0);
        s_ex.delete(); s_ld.delete();
        check_eq("rstmid_v_en", v_wr_en, 4'h0);
        check_eq("rstmid_el_en", el_wr_en, 4'h0);
        check_eq("rstmid_ex_ready", ex_ready_o, 1'b1);
        check_eq("rstmid_ld_ready", ld_ready_o, 1'b1);
        check_eq("rstmid_pend", pend_o, 32'h0);
        check_eq("rstmid_idle", idle_o, 1'b1);
        reset = 1'b0;
        cycle(0, 0);
        check_eq("rstmid_after_v_en", v_wr_en, 4'h0);
        check_eq("rstmid_after_el_en", el_wr_en, 4'h0);

        // Zero-mask ld entry is accepted and granted without effect.
        s_ld.push_back(ent_t'{5'd9, 4'h0, 128'h1234});
        cycle(0, 1);
        check_eq("zmask_idle_t1", idle_o, 1'b0);
        check_eq("zmask_pend_t1", pend_o[9], 1'b0);
        cycle(0, 0);
        check_eq("zmask_el_en", el_wr_en, 4'h0);
        check_eq("zmask_pend_t2", pend_o[9], 1'b0);
        check_eq("zmask_idle_t2", idle_o, 1'b1);

        // Random traffic with a reset pulse part way through.
        for (int i = 0; i < 150; i++) begin
            s_ex.push_back(rand_ent(3));
            s_ld.push_back(rand_ent(3));
        end
        guard = 0;
        while ((s_ex.size() > 0 || s_ld.size() > 0) && guard < 3000) begin
            reset = (guard == 120);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            guard++;
        end
        reset = 1'b0;
        check_eq("rand_drained", s_ex.size() + s_ld.size(), 0);
        cycle(0, 0); cycle(0, 0); cycle(0, 0); cycle(0, 0);
        check_eq("final_idle", idle_o, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vrf_wb_arbiter.md
VRF_WB_ARBITER -- requirements
Module: vrf_wb_arbiter

Interface
REQ-001 SHALL have parameter VREGS, default 32, number of vector registers.
REQ-002 SHALL have parameter ELEMENTS, default 4, elements per register.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, element width in bits.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, entries per source queue (power of two, >=2).
REQ-005 SHALL use one clock and a synchronous active-high reset: clk_i  in  1  clock; reset  in  1  sync reset, active high.
REQ-006 ex_valid_i  in  1  execution-unit result valid; ex_ready_o  out  1  execution queue not full.
REQ-007 ex_addr_i  in  $clog2(VREGS)  destination register; ex_mask_i  in  ELEMENTS  element write mask; ex_data_i  in  ELEMENTS*DATA_WIDTH  flat register data.
REQ-008 ld_valid_i  in  1  load-unit element result valid; ld_ready_o  out  1  load queue not full.
REQ-009 ld_addr_i  in  $clog2(VREGS)  destination register; ld_mask_i  in  ELEMENTS  element mask; ld_data_i  in  ELEMENTS x DATA_WIDTH  packed element array.
REQ-010 v_wr_en / v_wr_addr / v_wr_data  out  ELEMENTS / $clog2(VREGS) / ELEMENTS*DATA_WIDTH  register write port to VRF.
REQ-011 el_wr_en / el_wr_addr / el_wr_data  out  ELEMENTS / $clog2(VREGS) / ELEMENTS x DATA_WIDTH  element write port to VRF.
REQ-012 pend_o  out  VREGS  per-register pending-write flag; idle_o  out  1  both queues and output stage empty.

Function
REQ-013 Each source SHALL own a FIFO_DEPTH queue; entry accepted when valid and ready are high at a rising edge.
REQ-014 ready SHALL equal queue-not-full, independent of valid; no same-cycle pass-through when full.
REQ-015 Each cycle the arbiter SHALL pop at most one entry per source and load registered write outputs.
REQ-016 Merge: both heads valid, equal addr, (ex_mask & ld_mask)==0 -> pop both same cycle; v_wr_addr == el_wr_addr == common addr.
REQ-017 Conflict (both valid, not mergeable) -> round-robin; pointer resets to ex, flips to other source after each single-source grant, unchanged after a merge.
REQ-018 One head valid -> pop it regardless of pointer.
REQ-019 Ex grant drives v_wr_* with ex entry; ld grant drives el_wr_* with ld entry; ungranted port's en, addr, data SHALL be zero.
REQ-020 No grant in a cycle -> all write outputs zero next cycle.
REQ-021 Latency: handshake at edge t into empty queue, no conflict -> enables asserted during cycle t+2 (VRF writes at end of t+2).
REQ-022 Zero-mask entries SHALL be accepted, consume a grant, produce all-zero enables.
REQ-023 Per-source order SHALL be preserved; no entry lost or duplicated.
REQ-024 pend_o[r] SHALL be combinational: 1 while any queued entry or output-stage write targets r with nonzero mask.
REQ-025 idle_o SHALL be 1 iff both queues empty and all output enables zero.
REQ-026 Simultaneous push and pop on a full queue: push refused (ready low), pop proceeds.

Reset
REQ-027 While reset is high at an edge: queues emptied, rr pointer = ex, all write outputs zero.
REQ-028 Following that edge: ex_ready_o=ld_ready_o=1, pend_o=0, idle_o=1; reset mid-operation discards buffered and staged writes without any VRF write.

Structure
REQ-029 Typedef vrf_wb_req_t {addr, mask, data} and the source-select enum SHALL live in cellrv32_package.
REQ-030 Sub-module vrf_wb_fifo (parameterised depth, vrf_wb_req_t payload, full/empty) SHALL be instantiated once per source.

Verification
REQ-031 Single ex write addr 5, mask 4'b1111, data 0x11..44 at edge t -> v_wr_en=4'b1111, v_wr_addr=5 in cycle t+2; pend_o[5]=1 cycles t+1..t+2.
REQ-032 Same-cycle ex addr 3 mask 4'b0011 and ld addr 3 mask 4'b1100 -> one cycle with v_wr_en=4'b0011, el_wr_en=4'b1100, both addr 3.
REQ-033 Same-cycle ex addr 3 and ld addr 7, both mask 4'b1111, four pairs back-to-back -> grants strictly alternate ex,ld,ex,ld...; per-source order intact.
REQ-034 Hold ex_valid_i, block grants by competing ld traffic -> ex_ready_o drops after FIFO_DEPTH accepts; no entry lost.
REQ-035 Assert reset with both queues full -> no write enables after reset edge, readies 1, pend_o=0, idle_o=1.
REQ-036 ld entry with mask 4'b0000 -> accepted, granted, el_wr_en=0, pend_o unaffected.
